mem_access_ctrl: RTL
====================

# mem_access_ctrl

Single-port RAM access controller for the ARM datapath. It arbitrates between the instruction-fetch requester and the load/store (data) requester. It sequences each granted access through address setup, the RAM enable/MFC handshake and completion, and returns read data plus a one-cycle acknowledge to the winning requester. It sits between the control unit's MAR/MDR path and the byte-addressed RAM.

## Interface
- AW, 9, RAM byte-address width
- TIMEOUT_CYCLES, 255, max ACCESS cycles without MFC (only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; always a word read
- f_addr  in  AW  fetch address
- f_ack  out  1  fetch completion pulse
- d_req  in  1  data request
- d_rw  in  1  1 = write, 0 = read
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_ack  out  1  data completion pulse
- rdata  out  32  read result, valid with ack
- err  out  1  error flag, valid with ack
- busy  out  1  high in any state except IDLE
- ram_en  out  1  RAM enable (MOV)
- ram_rw  out  1  RAM write strobe
- ram_size  out  2  access size to RAM
- ram_addr  out  AW  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- mfc  in  1  memory function complete

## Operation
- States: IDLE -> ADDR -> ACCESS -> DONE -> IDLE.
- IDLE, arbitration:
  - Only one requester asserting: it wins.
  - Both asserting: data wins unless the last grant was data, in which case fetch wins (strict alternation under contention).
  - The last-grant register resets to "fetch", so the first simultaneous request goes to data.
- ADDR:
  - Latch the winner's addr, rw, size and wdata into internal registers. Drive ram_addr, ram_rw, ram_size and ram_wdata from those registers.
  - Misalignment: word with addr[1:0] != 0, halfword with addr[0] != 0, or size 11. The block goes directly to DONE with err=1 and no RAM access.
- ACCESS:
  - ram_en=1.
  - On mfc=1, a read captures ram_rdata into rdata, then the block goes to DONE.
- DONE:
  - ram_en=0.
  - Pulse the winner's ack for exactly one cycle, with err valid.
  - Update last-grant, then return to IDLE.
- Requesters hold req and operands stable until ack. Dropping req after ADDR does not abort the transaction; the ack is still pulsed.
- rdata holds its value until the next successful read. Writes and errors leave rdata unchanged.
- mfc is ignored in every state except ACCESS.

## Timing
- Reset values:
  - State IDLE; last-grant = fetch.
  - Outputs f_ack, d_ack, err, busy, ram_en, ram_rw all 0.
  - ram_size, ram_addr, ram_wdata and rdata all 0.
  - Timeout counter 0.
- clr asserted in any state: IDLE at the next edge, ram_en low, no ack issued, in-flight transaction discarded.
- Request sampled in IDLE at cycle 0:
  - ADDR at cycle 1.
  - ACCESS at cycle 2, with ram_en high from cycle 2.
- mfc seen at cycle k (k ≥ 2): ack at k+1, IDLE at k+2.
- Minimum latency, req to ack: 3 cycles.
- Back-to-back throughput: one access per 4 cycles.
- The requester must have req low by cycle k+2 if no new request is intended. A req still high at k+2 is taken as a new request.
- Misaligned access: ack at cycle 2.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without mfc.
  - When it reaches TIMEOUT_CYCLES, the block goes to DONE with err=1, ram_en drops, and rdata is unchanged.
- Undefined: ACCESS waits for mfc indefinitely, and err reports misalignment only.

## Structure
- Package arm_mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the state enum (IDLE, ADDR, ACCESS, DONE)
  - the grant enum (GNT_FETCH, GNT_DATA)
- Sub-module mfc_watchdog holds the timeout counter. It is instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Fetch alone:
  - Stimulus: f_addr=0x004, RAM word 0xE5910004, mfc asserted 2 cycles after ram_en.
  - Response: ram_en high cycles 2–4, f_ack at cycle 5, rdata=0xE5910004, err=0.
- Simultaneous requests after reset:
  - Stimulus: f_req and d_req (read 0x008) both asserted and held high.
  - Response: data serviced first (d_ack), then fetch (f_ack), then data again (alternation).
- Byte store:
  - Stimulus: d_rw=1, d_size=00, d_addr=0x00B, d_wdata=0x000000A6, mfc immediate.
  - Response: ram_rw=1, ram_size=00, ram_addr=0x00B, d_ack at cycle 3, rdata unchanged.
- Misaligned word load:
  - Stimulus: d_addr=0x009, d_size=10.
  - Response: ram_en never high, d_ack with err=1 at cycle 2.
- clr during ACCESS:
  - Stimulus: clr pulsed while waiting for mfc.
  - Response: IDLE next cycle, ram_en=0, no ack; a following fetch completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - Stimulus: mfc never asserted.
  - Response: ack with err=1 after 4 ACCESS cycles, busy low afterward.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: size encodings, controller states, grant ids and alignment helper for mem_access_ctrl
package arm_mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} memState_e;
   typedef enum logic {GNT_FETCH, GNT_DATA} grant_e;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lowAddr);
      return size == SZ_WORD ? lowAddr != 2'b00 : size == SZ_HALF ? lowAddr[0] : size != SZ_BYTE;
   endfunction
endpackage

// File: rtl/mfc_watchdog.sv
// mfc_watchdog: counts ACCESS cycles without mfc and flags the cycle whose increment reaches LIMIT
module mfc_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic clr,
   input  logic inAccess,
   input  logic mfc,
   output logic expired
);
   logic [7:0] count;
   always_ff @(posedge clk)
      if (clr || !inAccess) count <= '0;
      else if (!mfc) count <= count + 8'd1;
   assign expired = inAccess && !mfc && count == 8'(LIMIT - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: fetch/data arbiter and RAM handshake sequencer; ARB_TIMEOUT_EN adds an mfc timeout
module mem_access_ctrl
   import arm_mem_pkg::*;
#(
   parameter int AW = 9,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_ack,
   input  logic          d_req,
   input  logic          d_rw,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_ack,
   output logic [31:0]   rdata,
   output logic          err,
   output logic          busy,
   output logic          ram_en,
   output logic          ram_rw,
   output logic [1:0]    ram_size,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata,
   input  logic          mfc
);
   memState_e state, nextState;
   grant_e gnt, lastGnt, winner;
   logic [AW-1:0] addrQ;
   logic rwQ, errQ, errNext, timeout, anyReq;
   logic [1:0] sizeQ;
   logic [31:0] wdataQ, rdataQ;
   assign anyReq = f_req || d_req;
   // under contention data wins unless it also won last time
   assign winner = d_req && (!f_req || lastGnt == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
`ifdef ARB_TIMEOUT_EN
   mfc_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
      .clk(clk),
      .clr(clr),
      .inAccess(state == ACCESS),
      .mfc(mfc),
      .expired(timeout)
   );
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif
   always_comb begin
      nextState = state;
      errNext = errQ;
      case (state)
         IDLE: nextState = anyReq ? ADDR : IDLE;
         ADDR: begin
            errNext = misaligned(sizeQ, addrQ[1:0]);
            nextState = errNext ? DONE : ACCESS;
         end
         ACCESS: begin
            nextState = mfc || timeout ? DONE : ACCESS;
            errNext = !mfc && timeout;
         end
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         gnt <= GNT_FETCH;
         lastGnt <= GNT_FETCH;
         addrQ <= '0;
         rwQ <= 1'b0;
         sizeQ <= '0;
         wdataQ <= '0;
         rdataQ <= '0;
         errQ <= 1'b0;
      end else begin
         state <= nextState;
         errQ <= errNext;
         if (state == IDLE && anyReq) begin
            gnt <= winner;
            addrQ <= winner == GNT_DATA ? d_addr : f_addr;
            rwQ <= winner == GNT_DATA && d_rw;
            sizeQ <= winner == GNT_DATA ? d_size : SZ_WORD;
            wdataQ <= winner == GNT_DATA ? d_wdata : '0;
         end
         if (state == ACCESS && mfc && !rwQ) rdataQ <= ram_rdata;
         if (state == DONE) lastGnt <= gnt;
      end
   end
   assign busy = state != IDLE;
   assign ram_en = state == ACCESS;
   assign f_ack = state == DONE && gnt == GNT_FETCH;
   assign d_ack = state == DONE && gnt == GNT_DATA;
   assign err = state == DONE && errQ;
   assign rdata = rdataQ;
   assign ram_rw = rwQ;
   assign ram_size = sizeQ;
   assign ram_addr = addrQ;
   assign ram_wdata = wdataQ;
endmodule
